gpio_led_driver: RTL

- Consumes the single-bit GPIO output `q` of the servant SoC and drives the board's three active-low RGB LEDs.
- Red mirrors the GPIO level.
- Green is a pulse-stretched activity indicator that fires on every GPIO edge.
- Blue is an idle/stall indicator.
- All channels are PWM-dimmed; a lamp test runs after every reset. The block sits between servant and the LED pins in the top level, on the wb_clk domain.

---
 rtl/gpio_led_driver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/gpio_led_driver.sv
// RGB status LED driver for the servant GPIO: red mirrors q, green stretches
// every q edge, blue flags a long idle; all PWM-dimmed, with a lamp test after reset.
module gpio_led_driver #(
    parameter int PWM_BITS       = 8,
    parameter int DUTY_R         = 64,
    parameter int DUTY_G         = 64,
    parameter int DUTY_B         = 32,
    parameter int STRETCH_CYCLES = 1000000,
    parameter int IDLE_CYCLES    = 50000000,
    parameter int LAMP_CYCLES    = 10000000
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic q,
    output logic led_r,
    output logic led_g,
    output logic led_b
);

    localparam int SW        = $clog2(STRETCH_CYCLES + 1);
    localparam int IW        = $clog2(IDLE_CYCLES + 1);
    localparam int LW        = (LAMP_CYCLES > 0) ? $clog2(LAMP_CYCLES + 1) : 1;
    localparam int LAMP_LAST = (LAMP_CYCLES > 0) ? LAMP_CYCLES - 1 : 0;

    // Duties carry one extra bit so a duty of 2^PWM_BITS means always on.
    localparam logic [PWM_BITS:0] DR = (PWM_BITS + 1)'(DUTY_R);
    localparam logic [PWM_BITS:0] DG = (PWM_BITS + 1)'(DUTY_G);
    localparam logic [PWM_BITS:0] DB = (PWM_BITS + 1)'(DUTY_B);

    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX     = IW'(IDLE_CYCLES);
    localparam logic [LW-1:0] LAMP_END     = LW'(LAMP_LAST);

    typedef enum logic {
        ST_LAMP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (LAMP_CYCLES > 0) ? ST_LAMP : ST_RUN;

    state_t                state_q, state_d;
    logic                  q_s_q, q_s_d;
    logic                  q_d_q, q_d_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [SW-1:0]         stretch_q, stretch_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [LW-1:0]         lamp_q, lamp_d;
    logic                  led_r_q, led_r_d;
    logic                  led_g_q, led_g_d;
    logic                  led_b_q, led_b_d;

    logic q_edge;
    logic on_r, on_g, on_b;

    assign q_edge = (q_s_q != q_d_q);
    assign on_r   = ({1'b0, pwm_q} < DR);
    assign on_g   = ({1'b0, pwm_q} < DG);
    assign on_b   = ({1'b0, pwm_q} < DB);

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= RESET_STATE;
            q_s_q     <= 1'b0;
            q_d_q     <= 1'b0;
            pwm_q     <= '0;
            stretch_q <= '0;
            idle_q    <= '0;
            lamp_q    <= '0;
            led_r_q   <= 1'b1;
            led_g_q   <= 1'b1;
            led_b_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            q_s_q     <= q_s_d;
            q_d_q     <= q_d_d;
            pwm_q     <= pwm_d;
            stretch_q <= stretch_d;
            idle_q    <= idle_d;
            lamp_q    <= lamp_d;
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            led_b_q   <= led_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_s_d     = q;
        q_d_d     = q_s_q;
        pwm_d     = pwm_q + PWM_BITS'(1);
        stretch_d = stretch_q;
        idle_d    = idle_q;
        lamp_d    = lamp_q;
        led_r_d   = led_r_q;
        led_g_d   = led_g_q;
        led_b_d   = led_b_q;

        case (state_q)
            ST_LAMP: begin
                led_r_d   = 1'b0;
                led_g_d   = 1'b0;
                led_b_d   = 1'b0;
                lamp_d    = lamp_q + LW'(1);
                stretch_d = '0;
                idle_d    = '0;
                if (lamp_q == LAMP_END) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                led_r_d = !(q_s_q & on_r);
                // An edge always reloads / clears, overriding decrement or saturation.
                if (q_edge) begin
                    stretch_d = STRETCH_LOAD;
                    idle_d    = '0;
                end else begin
                    if (stretch_q != '0) stretch_d = stretch_q - SW'(1);
                    if (idle_q != IDLE_MAX) idle_d = idle_q + IW'(1);
                end
                led_g_d = !((stretch_q != '0) & on_g);
                led_b_d = !((idle_q == IDLE_MAX) & on_b);
            end
        endcase
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign led_b = led_b_q;

endmodule
